fpu_wb_stage: RTL and testbench

//  Downstream stage of the combinational fpu block. Gives long FPU paths (fdiv/fsqrt, fmul, fadd/fsub) a

---
 rtl/fpu_wb_stage.sv | 133 +++++++++++++
 tb/tb_fpu_wb_stage.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_wb_stage.sv
// Writeback stage behind the combinational FPU: stalls upstream for a per-class hold time,
// samples the FPU result, then offers it to register-file writeback. Optional: FPU_WB_EXC_EN.
module fpu_wb_stage #(
   parameter int LAT_MISC    = 1,
   parameter int LAT_ADDSUB  = 2,
   parameter int LAT_MUL     = 2,
   parameter int LAT_DIVSQRT = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        issue_valid,
   input  logic [1:0]  issue_class,
   input  logic [4:0]  issue_rd,
   input  logic        issue_to_int,
   input  logic [31:0] fpu_result,
   input  logic        kill,
   output logic        stall,
   output logic        wb_valid,
   input  logic        wb_ready,
   output logic [4:0]  wb_rd,
   output logic        wb_to_int,
`ifdef FPU_WB_EXC_EN
   input  logic        fpu_exc,
   input  logic        fflags_clr,
   output logic        wb_exc,
   output logic        fflags_ovf,
`endif
   output logic [31:0] wb_data
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0] state;
   logic [3:0] cnt;
   logic [3:0] issue_lat;
   logic       accept;
   logic       lat_multi;

   always_comb begin
      issue_lat = 4'(LAT_MISC);
      case (issue_class)
         2'd0:    issue_lat = 4'(LAT_MISC);
         2'd1:    issue_lat = 4'(LAT_ADDSUB);
         2'd2:    issue_lat = 4'(LAT_MUL);
         default: issue_lat = 4'(LAT_DIVSQRT);
      endcase
   end

   assign lat_multi = (issue_lat > 4'd1);
   assign accept    = issue_valid & ((state == IDLE) | ((state == DONE) & wb_ready)) & ~kill;

   // Stall releases in the sample cycle so upstream advances on the same edge the result is captured.
   assign stall = ~kill & ((accept & lat_multi)
                         | ((state == WAIT) & (cnt > 4'd1))
                         | ((state == DONE) & ~wb_ready));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         wb_valid  <= 1'b0;
         wb_rd     <= 5'd0;
         wb_to_int <= 1'b0;
         wb_data   <= 32'd0;
`ifdef FPU_WB_EXC_EN
         wb_exc    <= 1'b0;
`endif
      end else if (kill) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         wb_valid <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  wb_rd     <= issue_rd;
                  wb_to_int <= issue_to_int;
                  if (lat_multi) begin
                     cnt      <= issue_lat - 4'd1;
                     state    <= WAIT;
                     wb_valid <= 1'b0;
                  end else begin
                     wb_data  <= fpu_result;
`ifdef FPU_WB_EXC_EN
                     wb_exc   <= fpu_exc;
`endif
                     cnt      <= 4'd0;
                     state    <= DONE;
                     wb_valid <= 1'b1;
                  end
               end else if ((state == DONE) && wb_ready) begin
                  state    <= IDLE;
                  wb_valid <= 1'b0;
               end
            end
            WAIT: begin
               if (cnt > 4'd1) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  wb_data  <= fpu_result;
`ifdef FPU_WB_EXC_EN
                  wb_exc   <= fpu_exc;
`endif
                  cnt      <= 4'd0;
                  state    <= DONE;
                  wb_valid <= 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               cnt      <= 4'd0;
               wb_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef FPU_WB_EXC_EN
   // Sticky overflow flag; a flagged handshake wins over a clear in the same cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fflags_ovf <= 1'b0;
      end else if (wb_valid && wb_ready && wb_exc) begin
         fflags_ovf <= 1'b1;
      end else if (fflags_clr) begin
         fflags_ovf <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_fpu_wb_stage.sv
// Directed, scoreboard-checked bench for fpu_wb_stage; exception checks build with FPU_WB_EXC_EN.
module tb_fpu_wb_stage;

   typedef struct {
      logic [4:0]  rd;
      logic        to_int;
      logic [31:0] data;
   } wb_item_t;

   logic        clk;
   logic        rstn;
   logic        issue_valid;
   logic [1:0]  issue_class;
   logic [4:0]  issue_rd;
   logic        issue_to_int;
   logic [31:0] fpu_result;
   logic        kill;
   logic        stall;
   logic        wb_valid;
   logic        wb_ready;
   logic [4:0]  wb_rd;
   logic        wb_to_int;
   logic [31:0] wb_data;
`ifdef FPU_WB_EXC_EN
   logic        fpu_exc;
   logic        fflags_clr;
   logic        wb_exc;
   logic        fflags_ovf;
`endif

   int n_checks;
   int n_fail;
   wb_item_t exp_q[$];

   fpu_wb_stage dut (
      .clk          (clk),
      .rstn         (rstn),
      .issue_valid  (issue_valid),
      .issue_class  (issue_class),
      .issue_rd     (issue_rd),
      .issue_to_int (issue_to_int),
      .fpu_result   (fpu_result),
      .kill         (kill),
      .stall        (stall),
      .wb_valid     (wb_valid),
      .wb_ready     (wb_ready),
      .wb_rd        (wb_rd),
      .wb_to_int    (wb_to_int),
`ifdef FPU_WB_EXC_EN
      .fpu_exc      (fpu_exc),
      .fflags_clr   (fflags_clr),
      .wb_exc       (wb_exc),
      .fflags_ovf   (fflags_ovf),
`endif
      .wb_data      (wb_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic v, input logic [1:0] cls, input logic [4:0] rd,
                                input logic to_int, input logic [31:0] res);
      issue_valid  = v;
      issue_class  = cls;
      issue_rd     = rd;
      issue_to_int = to_int;
      fpu_result   = res;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic pushExpected(input logic [4:0] rd, input logic to_int, input logic [31:0] data);
      wb_item_t it;
      it.rd     = rd;
      it.to_int = to_int;
      it.data   = data;
      exp_q.push_back(it);
   endtask

   // Called while wb_valid & wb_ready are both high, i.e. just before the handshake edge.
   task automatic popCheck(input string tag);
      wb_item_t it;
      if (exp_q.size() == 0) begin
         checkOutput({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         it = exp_q.pop_front();
         checkOutput({tag, "_valid"},  32'(wb_valid),  32'd1);
         checkOutput({tag, "_data"},   wb_data,        it.data);
         checkOutput({tag, "_rd"},     32'(wb_rd),     32'(it.rd));
         checkOutput({tag, "_to_int"}, 32'(wb_to_int), 32'(it.to_int));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rstn     = 1'b0;
      kill     = 1'b0;
      wb_ready = 1'b0;
`ifdef FPU_WB_EXC_EN
      fpu_exc    = 1'b0;
      fflags_clr = 1'b0;
`endif
      applyStimulus(1'b0, 2'd0, 5'd0, 1'b0, 32'd0);

      #12;
      checkOutput("rst_valid", 32'(wb_valid), 32'd0);
      checkOutput("rst_data",  wb_data,       32'd0);
      checkOutput("rst_rd",    32'(wb_rd),    32'd0);
      checkOutput("rst_toint", 32'(wb_to_int), 32'd0);
      checkOutput("rst_stall", 32'(stall),    32'd0);
      rstn = 1'b1;
      tick();

      // Single-edge class 0 op
      wb_ready = 1'b1;
      applyStimulus(1'b1, 2'd0, 5'd5, 1'b0, 32'h3f800000);
      pushExpected(5'd5, 1'b0, 32'h3f800000);
      #1 checkOutput("t1_stall", 32'(stall), 32'd0);
      tick();
      applyStimulus(1'b0, 2'd0, 5'd0, 1'b0, 32'd0);
      #1 checkOutput("t1_stall_done", 32'(stall), 32'd0);
      popCheck("t1");
      tick();
      checkOutput("t1_idle_valid", 32'(wb_valid), 32'd0);

      // Class 3: result settles after edge 3, sampled on edge 4
      applyStimulus(1'b1, 2'd3, 5'd10, 1'b1, 32'h0);
      pushExpected(5'd10, 1'b1, 32'h40490fdb);
      #1 checkOutput("t2_stall_c1", 32'(stall), 32'd1);
      tick();
      checkOutput("t2_stall_c2", 32'(stall), 32'd1);
      checkOutput("t2_valid_c2", 32'(wb_valid), 32'd0);
      tick();
      checkOutput("t2_stall_c3", 32'(stall), 32'd1);
      tick();
      fpu_result = 32'h40490fdb;
      #1 checkOutput("t2_stall_c4", 32'(stall), 32'd0);
      checkOutput("t2_valid_c4", 32'(wb_valid), 32'd0);
      tick();
      applyStimulus(1'b0, 2'd0, 5'd0, 1'b0, 32'd0);
      #1 popCheck("t2");
      tick();
      checkOutput("t2_idle_valid", 32'(wb_valid), 32'd0);

      // Backpressure in DONE with a class 1 op waiting, then back-to-back acceptance
      wb_ready = 1'b0;
      applyStimulus(1'b1, 2'd0, 5'd7, 1'b0, 32'h11111111);
      pushExpected(5'd7, 1'b0, 32'h11111111);
      tick();
      applyStimulus(1'b1, 2'd1, 5'd8, 1'b0, 32'h22222222);
      for (int i = 0; i < 3; i++) begin
         #1;
         checkOutput($sformatf("t3_stall_%0d", i), 32'(stall), 32'd1);
         checkOutput($sformatf("t3_hold_%0d", i), wb_data, 32'h11111111);
         checkOutput($sformatf("t3_valid_%0d", i), 32'(wb_valid), 32'd1);
         tick();
      end
      wb_ready = 1'b1;
      #1 checkOutput("t3_stall_accept", 32'(stall), 32'd1);
      popCheck("t3a");
      pushExpected(5'd8, 1'b0, 32'h22222222);
      tick();
      checkOutput("t3_wait_valid", 32'(wb_valid), 32'd0);
      checkOutput("t3_wait_stall", 32'(stall), 32'd0);
      tick();
      applyStimulus(1'b0, 2'd0, 5'd0, 1'b0, 32'd0);
      #1 popCheck("t3b");
      tick();

      // Kill in the second cycle of a class 3 op
      applyStimulus(1'b1, 2'd3, 5'd3, 1'b0, 32'hdeadbeef);
      tick();
      kill = 1'b1;
      #1 checkOutput("t4_stall_kill", 32'(stall), 32'd0);
      tick();
      kill = 1'b0;
      applyStimulus(1'b0, 2'd0, 5'd0, 1'b0, 32'd0);
      for (int i = 0; i < 4; i++) begin
         #1;
         checkOutput($sformatf("t4_valid_%0d", i), 32'(wb_valid), 32'd0);
         checkOutput($sformatf("t4_stall_%0d", i), 32'(stall), 32'd0);
         tick();
      end

      // Asynchronous reset while holding a result in DONE
      wb_ready = 1'b0;
      applyStimulus(1'b1, 2'd0, 5'd9, 1'b1, 32'h5a5a5a5a);
      tick();
      applyStimulus(1'b0, 2'd0, 5'd0, 1'b0, 32'd0);
      checkOutput("t5_valid_pre", 32'(wb_valid), 32'd1);
      checkOutput("t5_data_pre",  wb_data,       32'h5a5a5a5a);
      #2 rstn = 1'b0;
      #1;
      checkOutput("t5_valid_rst", 32'(wb_valid), 32'd0);
      checkOutput("t5_data_rst",  wb_data,       32'd0);
      checkOutput("t5_rd_rst",    32'(wb_rd),    32'd0);
      #3 rstn = 1'b1;
      tick();

`ifdef FPU_WB_EXC_EN
      // Exception capture and sticky overflow flag
      wb_ready = 1'b1;
      fpu_exc  = 1'b1;
      applyStimulus(1'b1, 2'd1, 5'd4, 1'b0, 32'h7f800000);
      pushExpected(5'd4, 1'b0, 32'h7f800000);
      tick();
      tick();
      applyStimulus(1'b0, 2'd0, 5'd0, 1'b0, 32'd0);
      fpu_exc = 1'b0;
      #1 checkOutput("t6_wb_exc", 32'(wb_exc), 32'd1);
      popCheck("t6");
      tick();
      checkOutput("t6_ovf_set", 32'(fflags_ovf), 32'd1);
      fflags_clr = 1'b1;
      tick();
      fflags_clr = 1'b0;
      checkOutput("t6_ovf_clr", 32'(fflags_ovf), 32'd0);
      fpu_exc = 1'b1;
      applyStimulus(1'b1, 2'd0, 5'd6, 1'b0, 32'h00000001);
      pushExpected(5'd6, 1'b0, 32'h00000001);
      tick();
      applyStimulus(1'b0, 2'd0, 5'd0, 1'b0, 32'd0);
      fpu_exc    = 1'b0;
      fflags_clr = 1'b1;
      #1 popCheck("t6b");
      tick();
      fflags_clr = 1'b0;
      checkOutput("t6_ovf_set_wins", 32'(fflags_ovf), 32'd1);
`endif

      checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
